// File: rtl/vga_layer_compositor.sv
// vga_layer_compositor: VGA sync/timing generator plus a priority compositor
// for LAYERS rectangular overlay windows with double-buffered window registers.
//
// Optional build macro: VGA_TRANSPARENCY_EN -- when defined, a hit layer whose
// ROM data is 0 is transparent and priority falls through to the next layer.
//
// Ports:
//   iVGA_CLK, iRST_n       pixel clock, asynchronous active-low reset
//   win_we/win_sel/win_en  window register write (shadow copy)
//   win_x/win_y/win_w/win_h window position and size (w or h of 0 disables)
//   bg_index               background palette index (used at stage 2)
//   lyr_addr / lyr_data    per-layer ROM address out / data in (1-clock ROM)
//   oIndex                 composited palette index
//   oHS/oVS/oBLANK_n       active-low syncs and blank, aligned with oIndex
//   frame_start            1-clock pulse on first clock of vertical sync
//   frame_cnt              free-running frame counter
module vga_layer_compositor #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned LAYERS   = 4,
    parameter int unsigned IDX_W    = 8,
    parameter int unsigned AW       = 14,
    localparam int unsigned SEL_W   = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
    input  logic                      iVGA_CLK,
    input  logic                      iRST_n,
    input  logic                      win_we,
    input  logic [SEL_W-1:0]          win_sel,
    input  logic                      win_en,
    input  logic [9:0]                win_x,
    input  logic [8:0]                win_y,
    input  logic [9:0]                win_w,
    input  logic [8:0]                win_h,
    input  logic [IDX_W-1:0]          bg_index,
    output logic [LAYERS*AW-1:0]      lyr_addr,
    input  logic [LAYERS*IDX_W-1:0]   lyr_data,
    output logic [IDX_W-1:0]          oIndex,
    output logic                      oHS,
    output logic                      oVS,
    output logic                      oBLANK_n,
    output logic                      frame_start,
    output logic [15:0]               frame_cnt
);

    localparam int unsigned CW       = 11;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [CW-1:0]     hcnt, vcnt;
    logic              h_end_c, v_end_c, fs_next_c, active_c, hs_c, vs_c;

    logic [LAYERS-1:0] sh_en, act_en;
    logic [9:0]        sh_x [LAYERS];
    logic [8:0]        sh_y [LAYERS];
    logic [9:0]        sh_w [LAYERS];
    logic [8:0]        sh_h [LAYERS];
    logic [9:0]        act_x [LAYERS];
    logic [8:0]        act_y [LAYERS];
    logic [9:0]        act_w [LAYERS];
    logic [8:0]        act_h [LAYERS];

    logic [LAYERS-1:0] hit_c, hit_q1, hit_q2, line_hit;
    logic [AW-1:0]     row_base [LAYERS];
    logic [AW-1:0]     addr_q   [LAYERS];

    logic [2:0]        sync_q1, sync_q2, sync_q3;   // {hs, vs, blank_n}
    logic [IDX_W-1:0]  pix_c;

    // Stage 0 timing decode
    always_comb begin
        h_end_c   = (hcnt == CW'(H_TOTAL - 1));
        v_end_c   = (vcnt == CW'(V_TOTAL - 1));
        fs_next_c = h_end_c && (vcnt == CW'(VS_START - 1));
        active_c  = (hcnt < CW'(H_ACTIVE)) && (vcnt < CW'(V_ACTIVE));
        hs_c      = !((hcnt >= CW'(HS_START)) && (hcnt < CW'(HS_END)));
        vs_c      = !((vcnt >= CW'(VS_START)) && (vcnt < CW'(VS_END)));
    end

    // Stage 0 counters; frame_start is registered so it coincides with (0, VS_START)
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            hcnt        <= '0;
            vcnt        <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_start <= fs_next_c;
            if (frame_start) frame_cnt <= frame_cnt + 16'd1;
            if (h_end_c) begin
                hcnt <= '0;
                vcnt <= v_end_c ? '0 : vcnt + CW'(1);
            end else begin
                hcnt <= hcnt + CW'(1);
            end
        end
    end

    // Window registers: shadow written any time, active loaded at frame_start;
    // a write coinciding with frame_start goes straight into the active copy.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sh_en  <= '0;
            act_en <= '0;
            for (int l = 0; l < LAYERS; l++) begin
                sh_x[l]  <= '0; sh_y[l]  <= '0; sh_w[l]  <= '0; sh_h[l]  <= '0;
                act_x[l] <= '0; act_y[l] <= '0; act_w[l] <= '0; act_h[l] <= '0;
            end
        end else begin
            for (int l = 0; l < LAYERS; l++) begin
                if (win_we && (win_sel == SEL_W'(l))) begin
                    sh_en[l] <= win_en;
                    sh_x[l]  <= win_x; sh_y[l] <= win_y;
                    sh_w[l]  <= win_w; sh_h[l] <= win_h;
                end
                if (frame_start) begin
                    if (win_we && (win_sel == SEL_W'(l))) begin
                        act_en[l] <= win_en;
                        act_x[l]  <= win_x; act_y[l] <= win_y;
                        act_w[l]  <= win_w; act_h[l] <= win_h;
                    end else begin
                        act_en[l] <= sh_en[l];
                        act_x[l]  <= sh_x[l]; act_y[l] <= sh_y[l];
                        act_w[l]  <= sh_w[l]; act_h[l] <= sh_h[l];
                    end
                end
            end
        end
    end

    // Hit test with 11-bit sums so windows past the edge clip instead of wrapping
    always_comb begin
        hit_c = '0;
        for (int l = 0; l < LAYERS; l++) begin
            hit_c[l] = active_c && act_en[l]
                    && (act_w[l] != 10'd0) && (act_h[l] != 9'd0)
                    && (hcnt >= {1'b0, act_x[l]})
                    && (hcnt <  ({1'b0, act_x[l]} + {1'b0, act_w[l]}))
                    && (vcnt >= {2'b0, act_y[l]})
                    && (vcnt <  ({2'b0, act_y[l]} + {2'b0, act_h[l]}));
        end
    end

    // Stage 1: address generation; row stride is always the full window width
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            hit_q1   <= '0;
            hit_q2   <= '0;
            line_hit <= '0;
            for (int l = 0; l < LAYERS; l++) begin
                row_base[l] <= '0;
                addr_q[l]   <= '0;
            end
        end else begin
            hit_q1 <= hit_c;
            hit_q2 <= hit_q1;
            for (int l = 0; l < LAYERS; l++) begin
                if (hit_c[l]) begin
                    addr_q[l] <= (hcnt == {1'b0, act_x[l]}) ? row_base[l]
                                                            : addr_q[l] + AW'(1);
                end
                if (frame_start) begin
                    row_base[l] <= '0;
                    line_hit[l] <= 1'b0;
                end else if (h_end_c) begin
                    if (line_hit[l] || hit_c[l]) row_base[l] <= row_base[l] + AW'(act_w[l]);
                    line_hit[l] <= 1'b0;
                end else if (hit_c[l]) begin
                    line_hit[l] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        lyr_addr = '0;
        for (int l = 0; l < LAYERS; l++) lyr_addr[l*AW +: AW] = addr_q[l];
    end

    // Stage 2 priority: iterate high to low so the lowest-numbered hit wins
    always_comb begin
        pix_c = bg_index;
        for (int l = int'(LAYERS) - 1; l >= 0; l--) begin
`ifdef VGA_TRANSPARENCY_EN
            if (hit_q2[l] && (lyr_data[l*IDX_W +: IDX_W] != '0))
                pix_c = lyr_data[l*IDX_W +: IDX_W];
`else
            if (hit_q2[l]) pix_c = lyr_data[l*IDX_W +: IDX_W];
`endif
        end
    end

    // Sync delay line and stage 3 output register
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sync_q1 <= 3'b110;
            sync_q2 <= 3'b110;
            sync_q3 <= 3'b110;
            oIndex  <= '0;
        end else begin
            sync_q1 <= {hs_c, vs_c, active_c};
            sync_q2 <= sync_q1;
            sync_q3 <= sync_q2;
            oIndex  <= sync_q2[0] ? pix_c : '0;
        end
    end

    always_comb begin
        oHS      = sync_q3[2];
        oVS      = sync_q3[1];
        oBLANK_n = sync_q3[0];
    end

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Self-checking bench for vga_layer_compositor using a reduced 80x54 timing
// (64x48 visible) so several frames fit in a short run. Vectors are keyed by
// the number of clock edges since reset release; an output at cycle n
// reflects counter position n-3 (lyr_addr: n-1).
module tb_vga_layer_compositor;

    localparam int unsigned LAYERS = 2;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned AW     = 14;

    localparam int K_IDX = 0, K_A0 = 1, K_A1 = 2, K_BL = 3, K_HS = 4,
                   K_VS = 5, K_FS = 6, K_FC = 7, K_WR = 8;

    typedef struct {
        int unsigned at;
        int          kind;
        int unsigned sel;
        logic [15:0] a, b, c, d;
    } vec_t;

    logic                    clk, rst_n;
    logic                    win_we, win_en;
    logic [0:0]              win_sel;
    logic [9:0]              win_x, win_w;
    logic [8:0]              win_y, win_h;
    logic [IDX_W-1:0]        bg_index;
    logic [LAYERS*AW-1:0]    lyr_addr;
    logic [LAYERS*IDX_W-1:0] lyr_data;
    logic [IDX_W-1:0]        oIndex;
    logic                    oHS, oVS, oBLANK_n, frame_start;
    logic [15:0]             frame_cnt;

    int unsigned cyc;
    int          checks, errors;
    vec_t        vt[$];
    int          n1;

    vga_layer_compositor #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .LAYERS(LAYERS), .IDX_W(IDX_W), .AW(AW)
    ) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n),
        .win_we(win_we), .win_sel(win_sel), .win_en(win_en),
        .win_x(win_x), .win_y(win_y), .win_w(win_w), .win_h(win_h),
        .bg_index(bg_index), .lyr_addr(lyr_addr), .lyr_data(lyr_data),
        .oIndex(oIndex), .oHS(oHS), .oVS(oVS), .oBLANK_n(oBLANK_n),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM model: layer 0 returns its address, layer 1 returns 0x80 + address
    always @(posedge clk) begin
        lyr_data[7:0]  <= lyr_addr[7:0];
        lyr_data[15:8] <= 8'h80 + lyr_addr[AW+7:AW];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic void add(int unsigned at, int kind, int unsigned sel,
                                logic [15:0] a, logic [15:0] b, logic [15:0] c, logic [15:0] d);
        vec_t v;
        v.at = at; v.kind = kind; v.sel = sel; v.a = a; v.b = b; v.c = c; v.d = d;
        vt.push_back(v);
    endfunction

    function automatic void chk(int unsigned at, int kind, logic [15:0] e);
        add(at, kind, 0, e, 16'd0, 16'd0, 16'd0);
    endfunction

    function automatic string kname(int k);
        case (k)
            K_IDX:   return "oIndex";
            K_A0:    return "lyr_addr0";
            K_A1:    return "lyr_addr1";
            K_BL:    return "oBLANK_n";
            K_HS:    return "oHS";
            K_VS:    return "oVS";
            K_FS:    return "frame_start";
            default: return "frame_cnt";
        endcase
    endfunction

    function automatic logic [15:0] get_sig(int k);
        case (k)
            K_IDX:   return 16'(oIndex);
            K_A0:    return 16'(lyr_addr[AW-1:0]);
            K_A1:    return 16'(lyr_addr[2*AW-1:AW]);
            K_BL:    return 16'(oBLANK_n);
            K_HS:    return 16'(oHS);
            K_VS:    return 16'(oVS);
            K_FS:    return 16'(frame_start);
            default: return frame_cnt;
        endcase
    endfunction

    task automatic compare(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            while (cyc < vt[i].at) @(negedge clk);
            if (cyc != vt[i].at) begin
                checks++;
                errors++;
                $display("FAIL schedule vector %0d: got cyc %0d expected %0d", i, cyc, vt[i].at);
            end
            if (vt[i].kind == K_WR) begin
                win_we  = 1'b1;
                win_sel = 1'(vt[i].sel);
                win_en  = 1'b1;
                win_x   = 10'(vt[i].a);
                win_y   = 9'(vt[i].b);
                win_w   = 10'(vt[i].c);
                win_h   = 9'(vt[i].d);
                @(negedge clk);
                win_we  = 1'b0;
            end else begin
                compare(kname(vt[i].kind), get_sig(vt[i].kind), vt[i].a);
            end
        end
    endtask

    int hs_low, bl_high;

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; win_we = 1'b0; win_sel = '0; win_en = 1'b0;
        win_x = '0; win_y = '0; win_w = '0; win_h = '0; bg_index = 8'h55;

        // Frames 0-1: no layers
        chk(150, K_HS, 16'd1);   chk(151, K_HS, 16'd0);
        chk(158, K_HS, 16'd0);   chk(159, K_HS, 16'd1);
        chk(408, K_IDX, 16'h55); chk(408, K_BL, 16'd1);
        chk(473, K_IDX, 16'h00); chk(473, K_BL, 16'd0);
        chk(3848, K_IDX, 16'h00);
        chk(3999, K_FS, 16'd0);  chk(4000, K_FS, 16'd1); chk(4000, K_FC, 16'd0);
        chk(4001, K_FS, 16'd0);  chk(4001, K_FC, 16'd1);
        chk(4002, K_VS, 16'd1);  chk(4003, K_VS, 16'd0);
        chk(5943, K_IDX, 16'h55);
        add(8100, K_WR, 0, 16'd10, 16'd10, 16'd20, 16'd20);
        chk(8321, K_FC, 16'd2);
        // Frame 2: layer 0 at (10,10) 20x20; moved mid-frame (shadow only)
        chk(9451, K_A0, 16'd0);   chk(9452, K_IDX, 16'h55); chk(9453, K_IDX, 16'd0);
        chk(9470, K_A0, 16'd19);  chk(9472, K_IDX, 16'd19); chk(9473, K_IDX, 16'h55);
        chk(9531, K_A0, 16'd20);  chk(9533, K_IDX, 16'd20);
        add(9840, K_WR, 0, 16'd60, 16'd5, 16'd10, 16'd3);
        chk(10990, K_A0, 16'd399); chk(10992, K_IDX, 16'd143); chk(11053, K_IDX, 16'h55);
        // Frame 3: layer 0 at (60,5) 10x3, clipped at column 63
        chk(13421, K_A0, 16'd0);  chk(13424, K_A0, 16'd3);  chk(13426, K_IDX, 16'd3);
        chk(13501, K_A0, 16'd10); chk(13503, K_IDX, 16'd10);
        chk(13582, K_A0, 16'd21); chk(13663, K_IDX, 16'h55); chk(13773, K_IDX, 16'h55);
        add(14000, K_WR, 1, 16'd48, 16'd28, 16'd8, 16'd8);
        add(16960, K_WR, 0, 16'd50, 16'd30, 16'd4, 16'd4);   // same clock as frame_start
        chk(16962, K_FC, 16'd4);
        // Frame 4: layer 0 at (50,30) 4x4 over layer 1 at (48,28) 8x8
        chk(17743, K_IDX, 16'h55);
        chk(19569, K_A1, 16'd0);  chk(19570, K_IDX, 16'h55); chk(19571, K_IDX, 16'h80);
        chk(19731, K_A0, 16'd0);  chk(19731, K_A1, 16'd18);
`ifdef VGA_TRANSPARENCY_EN
        chk(19733, K_IDX, 16'h92);
`else
        chk(19733, K_IDX, 16'h00);
`endif
        chk(19734, K_IDX, 16'd1);
        chk(20138, K_IDX, 16'hBF);
        n1 = vt.size();
        // After mid-line reset: full interval to frame_start, layers disabled
        chk(2451, K_A0, 16'd0);   chk(2453, K_IDX, 16'h55);
        chk(3999, K_FS, 16'd0);   chk(4000, K_FS, 16'd1); chk(4001, K_FC, 16'd1);
        chk(6773, K_IDX, 16'h55);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_vecs(0, n1);

        // One full line of frame 4 (line 40): HS low and active pixel counts
        while (cyc < 20483) @(negedge clk);
        hs_low = 0; bl_high = 0;
        for (int i = 0; i < 80; i++) begin
            if (oHS == 1'b0) hs_low++;
            if (oBLANK_n == 1'b1) bl_high++;
            @(negedge clk);
        end
        compare("hs_low_count", 16'(hs_low), 16'd8);
        compare("blank_n_high_count", 16'(bl_high), 16'd64);

        // Asynchronous reset in the middle of an active line
        while (cyc < 20600) @(negedge clk);
        compare("oIndex_pre_reset", 16'(oIndex), 16'h55);
        #3 rst_n = 1'b0;
        #1;
        compare("rst_oIndex", 16'(oIndex), 16'd0);
        compare("rst_oHS", 16'(oHS), 16'd1);
        compare("rst_oVS", 16'(oVS), 16'd1);
        compare("rst_oBLANK_n", 16'(oBLANK_n), 16'd0);
        compare("rst_frame_start", 16'(frame_start), 16'd0);
        compare("rst_frame_cnt", frame_cnt, 16'd0);
        compare("rst_lyr_addr0", 16'(lyr_addr[AW-1:0]), 16'd0);
        compare("rst_lyr_addr1", 16'(lyr_addr[2*AW-1:AW]), 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_vecs(n1, vt.size());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
